// File: rtl/inert_spi_resp.sv
// ---------------------------------------------------------------------------
// inert_spi_resp
// SPI responder standing in for the inertial sensor on the far end of the
// inertial interface's SPI link. Serves 16-bit read/write frames (MSB first:
// R/W, 7-bit address, 8-bit data), holds a small register file and raises
// INT when a new pitch-rate / Z-accel sample has been applied.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   SS_n, SCLK, MOSI  SPI select / clock (mode 0) / data in, all asynchronous
//   MISO              SPI data out, high-Z while SS_n is high
//   INT               data-ready interrupt, active high
//   smpl_vld          one-clk pulse qualifying ptch_rt / az
//   ptch_rt, az       16-bit pitch-rate and Z-accel samples
//
// Build option:
//   SPI_RESP_AUTOINC_EN  when defined, read frames longer than 16 SCLKs
//                        continue as an auto-incrementing burst.
// ---------------------------------------------------------------------------
module inert_spi_resp #(
  parameter logic [7:0]  WHO_AM_I_VAL = 8'h6A,
  parameter int unsigned INT_EN_BIT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic        smpl_vld,
  input  logic [15:0] ptch_rt,
  input  logic [15:0] az
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_END} state_t;

  localparam logic [6:0] ADDR_INT1_CTRL = 7'h0D;
  localparam logic [6:0] ADDR_WHO_AM_I  = 7'h0F;
  localparam logic [6:0] ADDR_CTRL1_XL  = 7'h10;
  localparam logic [6:0] ADDR_CTRL2_G   = 7'h11;
  localparam logic [6:0] ADDR_PTCH_L    = 7'h22;
  localparam logic [6:0] ADDR_PTCH_H    = 7'h23;
  localparam logic [6:0] ADDR_AZ_L      = 7'h2C;
  localparam logic [6:0] ADDR_AZ_H      = 7'h2D;

  // Synchronizers: two flops for metastability plus one history flop so
  // edges are detected on the synchronized copy.
  logic [2:0] ssSync_q, sclkSync_q;
  logic [1:0] mosiSync_q;
  logic       ssHigh, ssFall, ssRise, sclkRise, sclkFall, mosiBit;

  state_t     state_q, state_d;
  logic [3:0] bitCnt_q, bitCnt_d;
  logic [6:0] rxShift_q, rxShift_d;
  logic [7:0] rxNext;
  logic [7:0] txShift_q, txShift_d;
  logic       rw_q, rw_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] wrData_q, wrData_d;
  logic       done_q, done_d;
  logic       read23_q, read23_d;

  logic [7:0]  intCtrl_q, intCtrl_d, ctrl1_q, ctrl1_d, ctrl2_q, ctrl2_d;
  logic [15:0] ptch_q, ptch_d, az_q, az_d;
  logic [15:0] pendPtch_q, pendPtch_d, pendAz_q, pendAz_d;
  logic        pend_q, pend_d, pendGo_q, pendGo_d;
  logic        applied_q, applied_d, intFlag_q, intFlag_d;

  assign ssHigh   = ssSync_q[1];
  assign ssFall   = ~ssSync_q[1] &  ssSync_q[2];
  assign ssRise   =  ssSync_q[1] & ~ssSync_q[2];
  assign sclkRise =  sclkSync_q[1] & ~sclkSync_q[2];
  assign sclkFall = ~sclkSync_q[1] &  sclkSync_q[2];
  assign mosiBit  = mosiSync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssSync_q   <= 3'b111;
      sclkSync_q <= 3'b000;
      mosiSync_q <= 2'b00;
    end else begin
      ssSync_q   <= {ssSync_q[1:0], SS_n};
      sclkSync_q <= {sclkSync_q[1:0], SCLK};
      mosiSync_q <= {mosiSync_q[0], MOSI};
    end
  end

  // Read mux for the register map; unmapped addresses read as zero.
  function automatic logic [7:0] readReg(input logic [6:0] a);
    logic [7:0] val;
    val = 8'h00;
    case (a)
      ADDR_INT1_CTRL: val = intCtrl_q;
      ADDR_WHO_AM_I:  val = WHO_AM_I_VAL;
      ADDR_CTRL1_XL:  val = ctrl1_q;
      ADDR_CTRL2_G:   val = ctrl2_q;
      ADDR_PTCH_L:    val = ptch_q[7:0];
      ADDR_PTCH_H:    val = ptch_q[15:8];
      ADDR_AZ_L:      val = az_q[7:0];
      ADDR_AZ_H:      val = az_q[15:8];
      default:        val = 8'h00;
    endcase
    return val;
  endfunction

`ifdef SPI_RESP_AUTOINC_EN
  logic [6:0] addrInc;
  assign addrInc = addr_q + 7'd1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bitCnt_q  <= '0;
      rxShift_q <= '0;
      txShift_q <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wrData_q  <= '0;
      done_q    <= 1'b0;
      read23_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      rxShift_q <= rxShift_d;
      txShift_q <= txShift_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wrData_q  <= wrData_d;
      done_q    <= done_d;
      read23_q  <= read23_d;
    end
  end

  // Frame FSM. bitCnt counts SCLK rises modulo 16; a byte completes on
  // every DATA-state rise whose low three bits read 7. The fall right after
  // a byte load must not shift, hence the phase-0 exclusion on falls.
  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    rxShift_d = rxShift_q;
    txShift_d = txShift_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wrData_d  = wrData_q;
    done_d    = done_q;
    read23_d  = read23_q;
    rxNext    = {rxShift_q, mosiBit};
    case (state_q)
      IDLE: begin
        if (ssFall) begin
          state_d   = CMD;
          bitCnt_d  = '0;
          rxShift_d = '0;
          done_d    = 1'b0;
          read23_d  = 1'b0;
        end
      end
      CMD: begin
        if (sclkRise) begin
          rxShift_d = rxNext[6:0];
          bitCnt_d  = bitCnt_q + 4'd1;
          if (bitCnt_q == 4'd7) begin
            rw_d   = rxNext[7];
            addr_d = rxNext[6:0];
            if (rxNext[7]) txShift_d = readReg(rxNext[6:0]);
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (sclkRise) begin
          rxShift_d = rxNext[6:0];
          bitCnt_d  = bitCnt_q + 4'd1;
          if (bitCnt_q[2:0] == 3'd7) begin
            done_d = 1'b1;
            if (rw_q && (addr_q == ADDR_PTCH_H)) read23_d = 1'b1;
            if (!rw_q) wrData_d = rxNext;
`ifdef SPI_RESP_AUTOINC_EN
            if (rw_q) begin
              addr_d    = addrInc;
              txShift_d = readReg(addrInc);
            end else begin
              state_d = WAIT_END;
            end
`else
            state_d = WAIT_END;
`endif
          end
        end else if (sclkFall && (bitCnt_q[2:0] != 3'd0)) begin
          txShift_d = {txShift_q[6:0], 1'b0};
        end
      end
      WAIT_END: begin
      end
      default: state_d = IDLE;
    endcase
    if (ssRise) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intCtrl_q  <= '0;
      ctrl1_q    <= '0;
      ctrl2_q    <= '0;
      ptch_q     <= '0;
      az_q       <= '0;
      pendPtch_q <= '0;
      pendAz_q   <= '0;
      pend_q     <= 1'b0;
      pendGo_q   <= 1'b0;
      applied_q  <= 1'b0;
      intFlag_q  <= 1'b0;
    end else begin
      intCtrl_q  <= intCtrl_d;
      ctrl1_q    <= ctrl1_d;
      ctrl2_q    <= ctrl2_d;
      ptch_q     <= ptch_d;
      az_q       <= az_d;
      pendPtch_q <= pendPtch_d;
      pendAz_q   <= pendAz_d;
      pend_q     <= pend_d;
      pendGo_q   <= pendGo_d;
      applied_q  <= applied_d;
      intFlag_q  <= intFlag_d;
    end
  end

  // Register file, sample capture and interrupt. Writes and the INT clear
  // take effect only when the frame ends; a sample arriving mid-frame is
  // parked and released one clock after SS_n rises, unless a newer sample
  // lands directly first. A set on the same clock as a clear wins.
  always_comb begin
    intCtrl_d  = intCtrl_q;
    ctrl1_d    = ctrl1_q;
    ctrl2_d    = ctrl2_q;
    ptch_d     = ptch_q;
    az_d       = az_q;
    pendPtch_d = pendPtch_q;
    pendAz_d   = pendAz_q;
    pend_d     = pend_q;
    pendGo_d   = ssRise & pend_q;
    applied_d  = 1'b0;
    intFlag_d  = intFlag_q;

    if (ssRise && done_q && !rw_q) begin
      case (addr_q)
        ADDR_INT1_CTRL: intCtrl_d = wrData_q;
        ADDR_CTRL1_XL:  ctrl1_d   = wrData_q;
        ADDR_CTRL2_G:   ctrl2_d   = wrData_q;
        default: ;
      endcase
    end

    if (pendGo_q) pend_d = 1'b0;
    if (smpl_vld && ssHigh) begin
      ptch_d    = ptch_rt;
      az_d      = az;
      applied_d = 1'b1;
      pend_d    = 1'b0;
      pendGo_d  = 1'b0;
    end else if (pendGo_q) begin
      ptch_d    = pendPtch_q;
      az_d      = pendAz_q;
      applied_d = 1'b1;
    end
    if (smpl_vld && !ssHigh) begin
      pend_d     = 1'b1;
      pendPtch_d = ptch_rt;
      pendAz_d   = az;
    end

    if (ssRise && done_q && rw_q && read23_q) intFlag_d = 1'b0;
    if (applied_q && intCtrl_q[INT_EN_BIT]) intFlag_d = 1'b1;
  end

  assign INT  = intFlag_q;
  assign MISO = SS_n ? 1'bz : ((state_q == DATA) ? txShift_q[7] : 1'b0);

endmodule

// File: tb/tb_inert_spi_resp.sv
// ---------------------------------------------------------------------------
// tb_inert_spi_resp
// Drives SPI frames and samples into inert_spi_resp and checks MISO read
// data and INT against a register-level model of the sensor.
// ---------------------------------------------------------------------------
module tb_inert_spi_resp;

`ifdef SPI_RESP_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b0;
  logic        MOSI = 1'b0;
  logic        smpl_vld = 1'b0;
  logic [15:0] ptch_rt = '0;
  logic [15:0] az = '0;
  wire         MISO;
  wire         INT;

  int testsRun = 0;
  int testsFailed = 0;

  // Sensor model: writable registers, sample registers, pending sample.
  logic [7:0]  mIntCtrl, mCtrl1, mCtrl2;
  logic [15:0] mPtch, mAz, mPendPtch, mPendAz;
  bit          mPend;
  bit          expInt = 1'b0;
  bit          intCheckEn = 1'b0;
  logic [7:0]  lastRead;
  logic [31:0] lastGot;

  inert_spi_resp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .INT      (INT),
    .smpl_vld (smpl_vld),
    .ptch_rt  (ptch_rt),
    .az       (az)
  );

  always #5 clk = ~clk;

  // Fail-safe so the run can never hang.
  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] modelRead(input logic [6:0] a);
    case (a)
      7'h0D:   return mIntCtrl;
      7'h0F:   return 8'h6A;
      7'h10:   return mCtrl1;
      7'h11:   return mCtrl2;
      7'h22:   return mPtch[7:0];
      7'h23:   return mPtch[15:8];
      7'h2C:   return mAz[7:0];
      7'h2D:   return mAz[15:8];
      default: return 8'h00;
    endcase
  endfunction

  task automatic modelWrite(input logic [6:0] a, input logic [7:0] d);
    case (a)
      7'h0D:   mIntCtrl = d;
      7'h10:   mCtrl1 = d;
      7'h11:   mCtrl2 = d;
      default: ;
    endcase
  endtask

  task automatic modelApply(input logic [15:0] p, input logic [15:0] a);
    mPtch = p;
    mAz = a;
    if (mIntCtrl[1]) expInt = 1'b1;
  endtask

  task automatic modelReset();
    mIntCtrl = '0; mCtrl1 = '0; mCtrl2 = '0;
    mPtch = '0; mAz = '0; mPendPtch = '0; mPendAz = '0;
    mPend = 1'b0;
    expInt = 1'b0;
  endtask

  // INT is compared every clock except in the short settling windows that
  // follow a sample pulse or the end of a frame.
  always @(negedge clk) begin
    if (rst_n && intCheckEn) checkOutput("int", {31'd0, INT}, {31'd0, expInt});
  end

  // One-clock smpl_vld pulse; outside a frame the model applies it at once,
  // inside a frame it is parked until the frame ends.
  task automatic pulseSample(input logic [15:0] p, input logic [15:0] a, input bit inFrame);
    if (!inFrame) intCheckEn = 1'b0;
    @(negedge clk);
    ptch_rt = p;
    az = a;
    smpl_vld = 1'b1;
    @(negedge clk);
    smpl_vld = 1'b0;
    if (inFrame) begin
      mPend = 1'b1;
      mPendPtch = p;
      mPendAz = a;
    end else begin
      modelApply(p, a);
      waitClk(4);
      intCheckEn = 1'b1;
    end
  endtask

  // One SPI frame of nBits SCLKs. MISO is sampled just before each rise, as
  // a mode-0 initiator would. injectAt >= 0 pulses a sample during that bit.
  task automatic applyStimulus(input bit isRead, input logic [6:0] addr,
                               input logic [7:0] data, input int nBits,
                               input int injectAt, input logic [15:0] injPtch,
                               input logic [15:0] injAz);
    logic [15:0] frame;
    logic [31:0] got, expBits;
    logic        cmdBits;
    bit          clr;
    frame = {isRead, addr, data};
    got = '0;
    cmdBits = 1'b0;
    @(negedge clk);
    SS_n = 1'b0;
    waitClk(8);
    for (int b = 0; b < nBits; b++) begin
      MOSI = (b < 16) ? frame[15 - b] : 1'b0;
      if (b == injectAt) begin
        pulseSample(injPtch, injAz, 1'b1);
        waitClk(2);
      end else begin
        waitClk(4);
      end
      if (b < 8) cmdBits = cmdBits | MISO;
      else got = {got[30:0], MISO};
      SCLK = 1'b1;
      waitClk(8);
      SCLK = 1'b0;
      waitClk(4);
    end
    MOSI = 1'b0;
    waitClk(4);
    intCheckEn = 1'b0;
    SS_n = 1'b1;

    checkOutput("cmdMiso", {31'd0, cmdBits}, 32'd0);
    if (isRead && nBits > 8) begin
      expBits = '0;
      for (int j = 0; j < nBits - 8; j++) begin
        int         byteIdx;
        logic [6:0] a;
        logic [7:0] byt;
        byteIdx = j / 8;
        a = addr + byteIdx[6:0];
        byt = (AUTOINC || byteIdx == 0) ? modelRead(a) : 8'h00;
        expBits = {expBits[30:0], byt[7 - (j % 8)]};
      end
      checkOutput("readBits", got, expBits);
    end
    lastGot = got;
    lastRead = (nBits >= 16) ? 8'(got >> (nBits - 16)) : 8'h00;

    clr = 1'b0;
    if (nBits >= 16 && !isRead) modelWrite(addr, data);
    if (nBits >= 16 && isRead) begin
      int nBytes;
      nBytes = AUTOINC ? 1 + (nBits - 16) / 8 : 1;
      for (int k = 0; k < nBytes; k++) begin
        logic [6:0] a;
        a = addr + 7'(k);
        if (a == 7'h23) clr = 1'b1;
      end
    end
    if (clr) expInt = 1'b0;
    if (mPend) begin
      mPend = 1'b0;
      modelApply(mPendPtch, mPendAz);
    end
    waitClk(10);
    intCheckEn = 1'b1;
  endtask

  task automatic readReg(input logic [6:0] addr);
    applyStimulus(1'b1, addr, 8'h00, 16, -1, 16'h0, 16'h0);
  endtask

  task automatic writeReg(input logic [6:0] addr, input logic [7:0] data);
    applyStimulus(1'b0, addr, data, 16, -1, 16'h0, 16'h0);
  endtask

  // Directed scenarios first, then a randomized mix of frames and samples.
  initial begin
    logic [6:0] addrTable [8];
    addrTable = '{7'h0D, 7'h0F, 7'h10, 7'h11, 7'h22, 7'h23, 7'h2C, 7'h2D};
    modelReset();
    waitClk(3);
    checkOutput("intReset", {31'd0, INT}, 32'd0);
    rst_n = 1'b1;
    waitClk(4);
    intCheckEn = 1'b1;

    readReg(7'h0F);
    checkOutput("whoAmI", {24'd0, lastRead}, 32'h6A);
    writeReg(7'h0D, 8'h02);
    readReg(7'h0D);
    checkOutput("intCtrlRb", {24'd0, lastRead}, 32'h02);
    writeReg(7'h0F, 8'h55);
    readReg(7'h0F);
    checkOutput("whoAmIRo", {24'd0, lastRead}, 32'h6A);

    // Exact data-ready latency after a sample with SS_n idle.
    intCheckEn = 1'b0;
    @(negedge clk);
    ptch_rt = 16'h1234;
    az = 16'h5678;
    smpl_vld = 1'b1;
    @(negedge clk);
    smpl_vld = 1'b0;
    checkOutput("intLat0", {31'd0, INT}, 32'd0);
    @(negedge clk);
    checkOutput("intLat1", {31'd0, INT}, 32'd1);
    modelApply(16'h1234, 16'h5678);
    intCheckEn = 1'b1;

    readReg(7'h22);
    checkOutput("ptchL", {24'd0, lastRead}, 32'h34);
    checkOutput("intHold", {31'd0, INT}, 32'd1);
    readReg(7'h23);
    checkOutput("ptchH", {24'd0, lastRead}, 32'h12);
    checkOutput("intClr", {31'd0, INT}, 32'd0);

    applyStimulus(1'b1, 7'h23, 8'h00, 16, 4, 16'hABCD, 16'h0101);
    checkOutput("ptchHOld", {24'd0, lastRead}, 32'h12);
    checkOutput("intReassert", {31'd0, INT}, 32'd1);
    readReg(7'h23);
    checkOutput("ptchHNew", {24'd0, lastRead}, 32'hAB);

    applyStimulus(1'b0, 7'h10, 8'hFF, 12, -1, 16'h0, 16'h0);
    readReg(7'h10);
    checkOutput("shortWrite", {24'd0, lastRead}, 32'h00);

    // Reset in the middle of a frame with a sample parked.
    pulseSample(16'h4321, 16'h0202, 1'b0);
    checkOutput("intPreRst", {31'd0, INT}, 32'd1);
    intCheckEn = 1'b0;
    @(negedge clk);
    SS_n = 1'b0;
    waitClk(8);
    for (int b = 0; b < 5; b++) begin
      MOSI = b[0];
      waitClk(4);
      SCLK = 1'b1;
      waitClk(8);
      SCLK = 1'b0;
      waitClk(4);
    end
    @(negedge clk);
    ptch_rt = 16'hBEEF;
    smpl_vld = 1'b1;
    @(negedge clk);
    smpl_vld = 1'b0;
    waitClk(2);
    rst_n = 1'b0;
    waitClk(2);
    checkOutput("intRstMid", {31'd0, INT}, 32'd0);
    SS_n = 1'b1;
    MOSI = 1'b0;
    waitClk(4);
    rst_n = 1'b1;
    modelReset();
    waitClk(6);
    intCheckEn = 1'b1;
    readReg(7'h0F);
    checkOutput("whoAmIPostRst", {24'd0, lastRead}, 32'h6A);
    readReg(7'h23);
    checkOutput("pendDiscard", {24'd0, lastRead}, 32'h00);

    writeReg(7'h0D, 8'h02);
    pulseSample(16'h1234, 16'h0000, 1'b0);
    applyStimulus(1'b1, 7'h22, 8'h00, 24, -1, 16'h0, 16'h0);
`ifdef SPI_RESP_AUTOINC_EN
    checkOutput("burstBytes", {16'd0, lastGot[15:0]}, 32'h3412);
    checkOutput("burstIntClr", {31'd0, INT}, 32'd0);
`else
    checkOutput("extraSclk", {16'd0, lastGot[15:0]}, 32'h3400);
    checkOutput("extraSclkInt", {31'd0, INT}, 32'd1);
`endif

    for (int it = 0; it < 40; it++) begin
      int         op, nBits, inj;
      logic [6:0] addr;
      op = $urandom_range(0, 9);
      addr = ($urandom_range(0, 4) == 0) ? 7'($urandom) : addrTable[$urandom_range(0, 7)];
      if (op < 2) begin
        pulseSample(16'($urandom), 16'($urandom), 1'b0);
      end else begin
        case ($urandom_range(0, 5))
          0:       nBits = $urandom_range(4, 15);
          1:       nBits = $urandom_range(17, 32);
          default: nBits = 16;
        endcase
        inj = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nBits - 1) : -1;
        applyStimulus(op[0], addr, 8'($urandom), nBits, inj,
                      16'($urandom), 16'($urandom));
      end
    end

    intCheckEn = 1'b0;
    waitClk(2);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
